// File: rtl/msg_frame_serializer.sv
// msg_frame_serializer
//   Turns a parallel message into a serial frame and shifts it out on a
//   programmable bit period. The frame is a start bit (0), the data LSB first,
//   an optional parity bit and STOP_BITS stop bits (1). A one-deep holding
//   buffer lets a second message queue up behind the frame on the line, so
//   back-to-back frames leave with no idle gap.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active low
//   msg      : message to send, sampled on the accepting edge
//   start    : request strobe, accepted on an edge where ready=1
//   ready    : holding buffer empty, a start will be accepted
//   busy     : a frame is on the line
//   done     : one-cycle pulse when a frame's last stop bit completes
//   out_reg  : shift register contents, bit 0 is the bit on the line
//   out_main : serial line, idle high
module msg_frame_serializer #(
  parameter int MSG_W      = 5,
  parameter int DIV        = 1023,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  localparam int FRAME_W   = 1 + MSG_W + PARITY_EN + STOP_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MSG_W-1:0]   msg,
  input  logic               start,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] out_reg,
  output logic               out_main
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               buf_full_q, buf_full_d;
  logic [MSG_W-1:0]   buf_q, buf_d;

  logic baud_term;
  logic frame_end;

  // Frame image with the start bit in bit 0 so it leaves the line first.
  function automatic logic [FRAME_W-1:0] frame_image(input logic [MSG_W-1:0] m);
    logic [FRAME_W-1:0] img;
    img          = '1;
    img[0]       = 1'b0;
    img[MSG_W:1] = m;
    if (PARITY_EN != 0) begin
      img[MSG_W+1] = (PARITY_ODD != 0) ? ~^m : ^m;
    end
    return img;
  endfunction

  // With DIV=1 the counter sits at 0 and every cycle is a terminal count.
  assign baud_term = (baud_q == BAUD_LAST);
  assign frame_end = baud_term && (bit_q == BIT_LAST);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;

    unique case (state_q)
      IDLE: begin
        shift_d = '1;
        baud_d  = '0;
        bit_d   = '0;
        busy_d  = 1'b0;
        if (start) begin
          shift_d = frame_image(msg);
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end

      SEND: begin
        if (frame_end) begin
          done_d = 1'b1;
          baud_d = '0;
          bit_d  = '0;
          // A queued message wins; a start is only seen here when the buffer
          // is empty, and is then sent straight away without buffering.
          if (buf_full_q) begin
            shift_d    = frame_image(buf_q);
            buf_full_d = 1'b0;
          end else if (start) begin
            shift_d = frame_image(msg);
          end else begin
            shift_d = '1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          if (start && !buf_full_q) begin
            buf_d      = msg;
            buf_full_d = 1'b1;
          end
          if (baud_term) begin
            baud_d  = '0;
            shift_d = {1'b1, shift_q[FRAME_W-1:1]};
            bit_d   = bit_q + 1'b1;
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '1;
      baud_q     <= '0;
      bit_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      buf_full_q <= buf_full_d;
    end
  end

  // Buffer payload is only meaningful while buf_full_q is set, so it needs
  // no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign ready    = ~buf_full_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign out_reg  = shift_q;
  assign out_main = (state_q == SEND) ? shift_q[0] : 1'b1;

endmodule

// File: tb/tb_msg_frame_serializer.sv
// Testbench for msg_frame_serializer. Four instances cover the parameter
// variants: even parity DIV=4, odd parity, no parity with two stop bits, and
// DIV=1. Line bits of the main instance are reassembled by a monitor and
// compared against frames queued when each start is driven.
module tb_msg_frame_serializer;

  localparam int MW   = 5;
  localparam int FW   = 8;
  localparam int TDIV = 4;

  typedef struct {
    logic [MW-1:0] m;
    logic [FW-1:0] img;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [MW-1:0] msg;
  logic          start_m, start_o, start_n, start_d;

  logic          ready_m, busy_m, done_m, line_m;
  logic [FW-1:0] reg_m;
  logic          ready_o, busy_o, done_o, line_o;
  logic [FW-1:0] reg_o;
  logic          ready_n, busy_n, done_n, line_n;
  logic [FW-1:0] reg_n;
  logic          ready_d, busy_d, done_d, line_d;
  logic [FW-1:0] reg_d;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  logic [FW-1:0] sb[$];

  always #5 clk = ~clk;

  msg_frame_serializer #(.MSG_W(MW), .DIV(TDIV), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_main (
    .clk(clk), .rst(rst), .msg(msg), .start(start_m), .ready(ready_m), .busy(busy_m),
    .done(done_m), .out_reg(reg_m), .out_main(line_m));

  msg_frame_serializer #(.MSG_W(MW), .DIV(TDIV), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .msg(msg), .start(start_o), .ready(ready_o), .busy(busy_o),
    .done(done_o), .out_reg(reg_o), .out_main(line_o));

  msg_frame_serializer #(.MSG_W(MW), .DIV(TDIV), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_np (
    .clk(clk), .rst(rst), .msg(msg), .start(start_n), .ready(ready_n), .busy(busy_n),
    .done(done_n), .out_reg(reg_n), .out_main(line_n));

  msg_frame_serializer #(.MSG_W(MW), .DIV(1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_d1 (
    .clk(clk), .rst(rst), .msg(msg), .start(start_d), .ready(ready_d), .busy(busy_d),
    .done(done_d), .out_reg(reg_d), .out_main(line_d));

  function automatic logic [FW-1:0] model_frame(input logic [MW-1:0] m, input bit odd, input bit pen);
    logic [FW-1:0] f;
    bit p;
    p    = odd;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < MW; i++) begin
      f[i+1] = m[i];
      p      = p ^ m[i];
    end
    if (pen) f[MW+1] = p;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_m(input logic [MW-1:0] m);
    msg     = m;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    sb.push_back(model_frame(m, 1'b0, 1'b1));
  endtask

  task automatic wait_done_m(input string name, input int lim);
    int n;
    n = 0;
    while (done_m !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    total++;
    if (done_m !== 1'b1) begin
      bad++;
      $display("FAIL %s: done=%b after %0d cycles want 1", name, done_m, lim);
    end
  endtask

  // Reassemble frames from the main line: detect the start bit, then sample
  // each bit one negedge into its DIV-cycle window.
  initial begin : line_monitor
    int cnt;
    bit act;
    logic [FW-1:0] bits;
    logic [FW-1:0] want;
    act  = 1'b0;
    cnt  = 0;
    bits = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        act = 1'b0;
      end else if (!act) begin
        if (line_m === 1'b0) begin
          act = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt % TDIV == 1) begin
          bits[cnt / TDIV] = line_m;
          if (cnt / TDIV == FW - 1) begin
            act = 1'b0;
            total++;
            if (sb.size() == 0) begin
              bad++;
              $display("FAIL sb_frame: got 0x%0h want <no frame queued>", bits);
            end else begin
              want = sb.pop_front();
              if (bits !== want) begin
                bad++;
                $display("FAIL sb_frame: got 0x%0h want 0x%0h", bits, want);
              end
            end
          end
        end
      end
    end
  end

  initial begin : done_counter
    forever begin
      @(negedge clk);
      if (done_m === 1'b1) done_cnt++;
    end
  end

  initial begin : main
    vec_t tbl[6];
    logic [FW-1:0] f;
    logic [FW-1:0] g;

    tbl[0] = '{5'b10110, 8'hEC};
    tbl[1] = '{5'h1F,    8'hFE};
    tbl[2] = '{5'h00,    8'h80};
    tbl[3] = '{5'h15,    8'hEA};
    tbl[4] = '{5'h01,    8'hC2};
    tbl[5] = '{5'h0A,    8'h94};

    start_m = 1'b0; start_o = 1'b0; start_n = 1'b0; start_d = 1'b0;
    msg = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    // Reset values with no clock edge yet
    chk("rst_line", line_m, 1);
    chk("rst_reg", reg_m, 8'hFF);
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_ready", ready_m, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Single frame with exact bit timing
    send_m(5'b10110);
    f = model_frame(5'b10110, 1'b0, 1'b1);
    chk("sf_reg", reg_m, 8'hEC);
    chk("sf_line0", line_m, 0);
    chk("sf_busy", busy_m, 1);
    chk("sf_ready", ready_m, 1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k < 32) begin
        chk($sformatf("sf_line_e%0d", k), line_m, f[k / TDIV]);
        chk($sformatf("sf_done_e%0d", k), done_m, 0);
      end else begin
        chk("sf_done_e32", done_m, 1);
        chk("sf_busy_e32", busy_m, 0);
        chk("sf_line_e32", line_m, 1);
        chk("sf_reg_e32", reg_m, 8'hFF);
      end
    end
    tick();
    chk("sf_done_e33", done_m, 0);

    // Table of messages and their frame images
    for (int i = 0; i < 6; i++) begin
      send_m(tbl[i].m);
      chk($sformatf("tbl%0d_reg", i), reg_m, tbl[i].img);
      chk($sformatf("tbl%0d_line", i), line_m, 0);
      wait_done_m($sformatf("tbl%0d_done", i), 60);
      tick();
      chk($sformatf("tbl%0d_idle", i), busy_m, 0);
    end

    // Back-to-back through the holding buffer
    send_m(5'h1F);
    repeat (4) tick();
    msg = 5'h00; start_m = 1'b1;
    tick();
    start_m = 1'b0;
    sb.push_back(model_frame(5'h00, 1'b0, 1'b1));
    chk("b2b_ready_e5", ready_m, 0);
    repeat (26) tick();
    chk("b2b_ready_e31", ready_m, 0);
    chk("b2b_done_e31", done_m, 0);
    tick();
    chk("b2b_done_e32", done_m, 1);
    chk("b2b_ready_e32", ready_m, 1);
    chk("b2b_busy_e32", busy_m, 1);
    chk("b2b_line_e32", line_m, 0);
    chk("b2b_reg_e32", reg_m, 8'h80);
    tick();
    chk("b2b_done_e33", done_m, 0);
    repeat (30) tick();
    chk("b2b_done_e63", done_m, 0);
    tick();
    chk("b2b_done_e64", done_m, 1);
    chk("b2b_busy_e64", busy_m, 0);
    chk("b2b_line_e64", line_m, 1);
    tick();

    // Overflow: third start while the buffer is full is dropped
    done_cnt = 0;
    send_m(5'h03);
    repeat (4) tick();
    msg = 5'h0C; start_m = 1'b1;
    tick();
    sb.push_back(model_frame(5'h0C, 1'b0, 1'b1));
    msg = 5'h11;
    tick();
    start_m = 1'b0;
    chk("ovf_ready_e6", ready_m, 0);
    repeat (70) tick();
    chk("ovf_done_cnt", done_cnt, 2);
    chk("ovf_busy", busy_m, 0);

    // Odd parity and no-parity/two-stop variants
    msg = 5'b10110; start_o = 1'b1; start_n = 1'b1;
    tick();
    start_o = 1'b0; start_n = 1'b0;
    chk("odd_reg", reg_o, 8'hAC);
    chk("odd_line", line_o, 0);
    chk("odd_ready", ready_o, 1);
    chk("np_reg", reg_n, 8'hEC);
    chk("np_busy", busy_n, 1);
    chk("np_ready", ready_n, 1);
    repeat (32) tick();
    chk("odd_done_e32", done_o, 1);
    chk("np_done_e32", done_n, 1);
    tick();
    chk("odd_busy_end", busy_o, 0);
    chk("np_line_end", line_n, 1);

    // DIV=1: one bit per cycle, then a start on the frame-end edge
    f = model_frame(5'h15, 1'b0, 1'b1);
    g = model_frame(5'h0A, 1'b0, 1'b1);
    msg = 5'h15; start_d = 1'b1;
    tick();
    start_d = 1'b0;
    chk("d1_reg", reg_d, 8'hEA);
    chk("d1_line_e0", line_d, f[0]);
    for (int k = 1; k < FW; k++) begin
      tick();
      chk($sformatf("d1_line_e%0d", k), line_d, f[k]);
    end
    chk("d1_done_e7", done_d, 0);
    msg = 5'h0A; start_d = 1'b1;
    tick();
    start_d = 1'b0;
    chk("d1_done_e8", done_d, 1);
    chk("d1_busy_e8", busy_d, 1);
    chk("d1_ready_e8", ready_d, 1);
    chk("d1_line_e8", line_d, 0);
    chk("d1_reg_e8", reg_d, 8'h94);
    for (int k = 1; k < FW; k++) begin
      tick();
      chk($sformatf("d1b_line_e%0d", k + 8), line_d, g[k]);
    end
    tick();
    chk("d1_done_e16", done_d, 1);
    chk("d1_busy_e16", busy_d, 0);
    chk("d1_line_e16", line_d, 1);

    // Asynchronous reset mid-frame with a message buffered
    send_m(5'h07);
    tick();
    msg = 5'h18; start_m = 1'b1;
    tick();
    start_m = 1'b0;
    chk("mrst_ready_pre", ready_m, 0);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("mrst_line", line_m, 1);
    chk("mrst_reg", reg_m, 8'hFF);
    chk("mrst_busy", busy_m, 0);
    chk("mrst_done", done_m, 0);
    chk("mrst_ready", ready_m, 1);
    sb.delete();
    tick();
    tick();
    rst = 1'b1;
    done_cnt = 0;
    repeat (40) tick();
    chk("mrst_no_done", done_cnt, 0);
    chk("mrst_line_idle", line_m, 1);
    chk("mrst_busy_idle", busy_m, 0);
    chk("odd_done_idle", done_o, 0);
    chk("np_done_idle", done_n, 0);

    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
